sd_sector_viewer: RTL

Captures one block of bytes streamed from `sd_controller` into an internal buffer and shows it on a time-multiplexed, parametrised N-digit seven-segment display. The user steps through the buffer with `next`/`prev` pulses. It sits between `sd_controller` and the board display in the SD top level, in place of the static two-digit byte display. It adds read sequencing, buffering, navigation and digit scanning.

---
 rtl/sd_view_pkg.sv | 18 +
 rtl/sd_sector_viewer_if.sv | 24 ++
 rtl/sd_sector_viewer_seg.sv | 30 +++
 rtl/sd_sector_viewer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sd_view_pkg.sv
// Shared types and constants for the SD sector viewer.
// Holds the capture FSM state type, the blank segment pattern and default sizing.
package sd_view_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      CAPTURE,
      DONE
   } view_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int unsigned DEF_DIGITS      = 4;
   localparam int unsigned DEF_BUF_DEPTH   = 512;
   localparam int unsigned DEF_REFRESH_DIV = 100000;

endpackage

// File: rtl/sd_sector_viewer_if.sv
// Byte-stream handshake between sd_controller and the sector viewer.
// The viewer drives rd (master); the controller drives ready, byte_available and sd_dout.
interface sd_sector_viewer_if;

   logic       rd;
   logic       ready;
   logic       byte_available;
   logic [7:0] sd_dout;

   modport master (
      output rd,
      input  ready,
      input  byte_available,
      input  sd_dout
   );

   modport slave (
      input  rd,
      output ready,
      output byte_available,
      output sd_dout
   );

endinterface

// File: rtl/sd_sector_viewer_seg.sv
// Hex nibble to active-low seven-segment pattern, Basys font.
// Segment order: bit 0 = a ... bit 6 = g.
module seven_seg_decoder (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (nibble)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/sd_sector_viewer.sv
// Captures one block from sd_controller into a BRAM and scans it onto an
// N-digit multiplexed seven-segment display with next/prev navigation.
module sd_sector_viewer
   import sd_view_pkg::*;
#(
   parameter int unsigned DIGITS      = DEF_DIGITS,
   parameter int unsigned BUF_DEPTH   = DEF_BUF_DEPTH,
   parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   sd_sector_viewer_if.master             sd,
   input  logic                           next,
   input  logic                           prev,
   input  logic                           mode,
   output logic                           busy,
   output logic                           capture_done,
   output logic [$clog2(BUF_DEPTH+1)-1:0] byte_count,
   output logic [6:0]                     seg,
   output logic [DIGITS-1:0]              an
);

   localparam int unsigned AW = $clog2(BUF_DEPTH);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned SW = $clog2(DIGITS);
   localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 2) ? (DIGITS - 2) * 4 : 4;

   localparam logic [CW-1:0] LAST_COUNT = CW'(BUF_DEPTH - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] SEL_LAST   = SW'(DIGITS - 1);

   view_state_e   state, state_nx;
   logic          rd_q, rd_nx;
   logic          ba_q, ba_rise, wr_en;
   logic [AW-1:0] view_idx;
   logic [7:0]    mem [BUF_DEPTH];

   logic [DW-1:0] div;
   logic [SW-1:0] sel;

   logic [AW-1:0] rd_addr;
   logic          in_range, is_idx;
   logic [IW-1:0] idx_word;
   logic [3:0]    idx_nib;

   logic [7:0]    rd_data;
   logic [SW-1:0] sel_d1;
   logic          hi_d1, in_range_d1, is_idx_d1, valid_d1;
   logic [3:0]    idx_nib_d1;

   logic [3:0]    nib;
   logic [6:0]    seg_dec;

   assign sd.rd   = rd_q;
   assign ba_rise = sd.byte_available & ~ba_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         rd_q  <= 1'b0;
      end else begin
         state <= state_nx;
         rd_q  <= rd_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = REQ;
         REQ:        if (rd_q) state_nx = CAPTURE;
         CAPTURE:    if (wr_en && byte_count == LAST_COUNT) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   // rd_nx drops once rd_q is up, so the request is a single-cycle pulse.
   always_comb begin
      busy         = 1'b0;
      capture_done = 1'b0;
      wr_en        = 1'b0;
      rd_nx        = 1'b0;
      case (state)
         REQ: begin
            busy  = 1'b1;
            rd_nx = sd.ready & ~rd_q;
         end
         CAPTURE: begin
            busy  = 1'b1;
            wr_en = ba_rise;
         end
         DONE:    capture_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ba_q       <= 1'b0;
         byte_count <= '0;
         view_idx   <= '0;
      end else begin
         ba_q <= sd.byte_available;
         if ((state == IDLE || state == DONE) && start) begin
            byte_count <= '0;
            view_idx   <= '0;
         end else if (wr_en) begin
            byte_count <= byte_count + CW'(1);
            view_idx   <= byte_count[AW-1:0];
         end else if (state == DONE && byte_count != '0 && (next ^ prev)) begin
            view_idx <= next ? view_idx + AW'(1) : view_idx - AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[byte_count[AW-1:0]] <= sd.sd_dout;
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div <= '0;
         sel <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         sel <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
      end else begin
         div <= div + DW'(1);
      end
   end

   // Digit address stage: mode 0 shows one byte plus the index, mode 1 a run of bytes.
   always_comb begin
      rd_addr = view_idx;
      is_idx  = 1'b0;
      if (mode) rd_addr = view_idx + AW'(sel >> 1);
      else      is_idx  = (sel > SW'(1));
      in_range = (CW'(rd_addr) < byte_count);
      idx_word = IW'(view_idx);
      idx_nib  = 4'(idx_word >> {sel - SW'(2), 2'b00});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_d1    <= 1'b0;
         sel_d1      <= '0;
         hi_d1       <= 1'b0;
         in_range_d1 <= 1'b0;
         is_idx_d1   <= 1'b0;
         idx_nib_d1  <= '0;
      end else begin
         valid_d1    <= 1'b1;
         sel_d1      <= sel;
         hi_d1       <= sel[0];
         in_range_d1 <= in_range;
         is_idx_d1   <= is_idx;
         idx_nib_d1  <= idx_nib;
      end
   end

   always_comb begin
      nib = 4'h0;
      if (is_idx_d1)        nib = idx_nib_d1;
      else if (in_range_d1) nib = hi_d1 ? rd_data[7:4] : rd_data[3:0];
   end

   seven_seg_decoder u_dec (
      .nibble (nib),
      .seg    (seg_dec)
   );

   // an and seg share one register stage so the digit enable never leads its pattern.
   always_ff @(posedge clk) begin
      if (reset || !valid_d1) begin
         an  <= '1;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(DIGITS'(1) << sel_d1);
         seg <= seg_dec;
      end
   end

endmodule
